block_sync: RTL and testbench
=============================

BLOCK_SYNC -- requirements
Module: block_sync

Interface
REQ-001 Parameter RX_DATA_WIDTH, default 64: payload width per 67b block, excluding the header.
REQ-002 Parameter SH_CNT_MAX, default 64: length of the header test window, in valid words.
REQ-003 Parameter SH_INVALID_CNT_MAX, default 16: number of invalid headers in one window that drops lock.
REQ-004 Parameter SLIP_WAIT, default 32: cycles ignored after a slip pulse, for gearbox settling.
REQ-005 USER_CLK  in  1  sole clock; all logic rising-edge.
REQ-006 SYSTEM_RESET_N  in  1  reset, asynchronous, active-low.
REQ-007 DATA_IN  in  RX_DATA_WIDTH  payload from the RX gearbox.
REQ-008 HEADER_IN  in  2  sync header from the RX gearbox.
REQ-009 DATA_IN_VALID  in  1  gearbox word strobe; words without it are ignored.
REQ-010 RXGEARBOX_SLIP  out  1  one-cycle pulse requesting a 1-bit gearbox slip.
REQ-011 DATA_OUT  out  RX_DATA_WIDTH  registered DATA_IN, feeding the descrambler.
REQ-012 HEADER_OUT  out  2  registered HEADER_IN.
REQ-013 DATA_OUT_VALID  out  1  DATA_IN_VALID AND BLOCK_LOCK, registered.
REQ-014 BLOCK_LOCK  out  1  block boundary acquired.

Function
REQ-015 A header is valid iff HEADER_IN is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
REQ-016 Datapath latency is 1 cycle. DATA_OUT and HEADER_OUT load only on cycles where DATA_IN_VALID=1. DATA_OUT_VALID updates every cycle.
REQ-017 The FSM has three states: TEST_SH, SLIP, WAIT. Reset enters TEST_SH.
REQ-018 sh_cnt counts valid-strobed words. sh_invalid_cnt counts invalid headers. Both are $clog2(MAX+1) bits wide and never wrap.
REQ-019 TEST_SH, unlocked: an invalid header causes RXGEARBOX_SLIP=1 on the next cycle, clears both counters and moves to SLIP.
REQ-020 TEST_SH, unlocked: the SH_CNT_MAX-th consecutive valid header sets BLOCK_LOCK=1 and clears the counters.
REQ-021 TEST_SH, locked: on reaching sh_cnt==SH_CNT_MAX with sh_invalid_cnt<SH_INVALID_CNT_MAX, clear both counters and stay locked.
REQ-022 TEST_SH, locked: the SH_INVALID_CNT_MAX-th invalid header within one window has these effects:
- BLOCK_LOCK=0
- slip pulse
- counters cleared
- move to SLIP
REQ-023 Simultaneous events: if the window end coincides with the invalid threshold, loss of lock wins.
REQ-024 SLIP lasts exactly one cycle with RXGEARBOX_SLIP=1, then moves to WAIT; RXGEARBOX_SLIP=0 in all other states.
REQ-025 WAIT holds for SLIP_WAIT cycles (a cycle counter, independent of DATA_IN_VALID), ignoring headers, then returns to TEST_SH.
REQ-026 DATA_IN_VALID=0 in TEST_SH freezes both counters and state.
REQ-027 BLOCK_LOCK changes only per REQ-020 and REQ-022, and is never asserted in SLIP or WAIT.

Reset
REQ-028 Asserting SYSTEM_RESET_N=0 at any time, including mid-slip or mid-wait, immediately forces the following:
- RXGEARBOX_SLIP=0
- BLOCK_LOCK=0
- DATA_OUT_VALID=0
- DATA_OUT=0
- HEADER_OUT=0
- all counters 0
- state TEST_SH
REQ-029 After deassertion, the first valid word is evaluated on the first rising edge; no extra hold-off applies.

Structure
REQ-030 Shared package interlaken_pkg holds:
- state encodings
- header constants SH_DATA=2'b01 and SH_CTRL=2'b10
- default window constants
REQ-031 Single module; no sub-module. The WAIT timer is inline.
REQ-032 Target size is 120-250 RTL lines.

Verification
REQ-033 Scenario 1: 64 valid headers after reset -> BLOCK_LOCK rises one cycle after the 64th word; DATA_OUT_VALID follows one cycle later.
REQ-034 Scenario 2: unlocked, header 2'b11 at word 10 -> exactly one RXGEARBOX_SLIP pulse, then no slip for 32 cycles, then TEST_SH with counters at 0.
REQ-035 Scenario 3: locked, 15 invalid headers in a 64-word window -> lock held and counters cleared at the window end; 16 invalid headers -> BLOCK_LOCK=0 plus a slip pulse.
REQ-036 Scenario 4: locked, 16th invalid header on the 64th word -> lock lost and slip issued (REQ-023).
REQ-037 Scenario 5: DATA_IN_VALID toggling 1/0 during acquisition -> lock only after 64 strobed words; DATA_OUT holds its value on non-strobed cycles.
REQ-038 Scenario 6: SYSTEM_RESET_N pulsed low during WAIT and while locked -> all outputs 0 immediately; the next acquisition needs 64 fresh valid words.

Source files
------------

// File: rtl/interlaken_pkg.sv
// Shared definitions for the Interlaken receive path: block-sync FSM states,
// sync-header codes and the default lock/slip window sizes.
package interlaken_pkg;

    // Block-sync FSM states
    typedef enum logic [1:0] {
        ST_TEST_SH = 2'd0,
        ST_SLIP    = 2'd1,
        ST_WAIT    = 2'd2
    } bs_state_e;

    // Sync header codes; 2'b00 and 2'b11 never appear on a correctly framed link
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // Default window sizes
    localparam int DEF_RX_DATA_WIDTH      = 64;
    localparam int DEF_SH_CNT_MAX         = 64;
    localparam int DEF_SH_INVALID_CNT_MAX = 16;
    localparam int DEF_SLIP_WAIT          = 32;

    // True when the two header bits form a legal data or control header
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/block_sync.sv
// 64b/67b block synchronisation: hunts for the sync-header boundary by
// slipping the RX gearbox one bit at a time, declares lock after a full window
// of clean headers, and drops lock when too many bad headers arrive within a
// window. Also registers the data/header stream towards the descrambler.
module block_sync
    import interlaken_pkg::*;
#(
    parameter int RX_DATA_WIDTH      = DEF_RX_DATA_WIDTH,
    parameter int SH_CNT_MAX         = DEF_SH_CNT_MAX,
    parameter int SH_INVALID_CNT_MAX = DEF_SH_INVALID_CNT_MAX,
    parameter int SLIP_WAIT          = DEF_SLIP_WAIT
) (
    input  logic                     USER_CLK,
    input  logic                     SYSTEM_RESET_N,
    input  logic [RX_DATA_WIDTH-1:0] DATA_IN,
    input  logic [1:0]               HEADER_IN,
    input  logic                     DATA_IN_VALID,
    output logic                     RXGEARBOX_SLIP,
    output logic [RX_DATA_WIDTH-1:0] DATA_OUT,
    output logic [1:0]               HEADER_OUT,
    output logic                     DATA_OUT_VALID,
    output logic                     BLOCK_LOCK
);

    localparam int SH_CW   = $clog2(SH_CNT_MAX + 1);
    localparam int INV_CW  = $clog2(SH_INVALID_CNT_MAX + 1);
    localparam int WAIT_CW = $clog2(SLIP_WAIT + 1);

    localparam logic [SH_CW-1:0]   SH_CNT_LAST  = SH_CW'(SH_CNT_MAX);
    localparam logic [INV_CW-1:0]  INV_CNT_LAST = INV_CW'(SH_INVALID_CNT_MAX);
    // WAIT counts 0 .. SLIP_WAIT-1, so it occupies exactly SLIP_WAIT cycles
    localparam logic [WAIT_CW-1:0] WAIT_LAST    = WAIT_CW'(SLIP_WAIT - 1);

    bs_state_e            state_q, state_d;
    logic [SH_CW-1:0]     sh_cnt_q, sh_cnt_d;
    logic [INV_CW-1:0]    sh_invalid_cnt_q, sh_invalid_cnt_d;
    logic [WAIT_CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic                 block_lock_q, block_lock_d;
    logic                 slip_q, slip_d;

    logic [RX_DATA_WIDTH-1:0] data_out_q;
    logic [1:0]               header_out_q;
    logic                     data_out_valid_q;

    logic                 hdr_bad;
    logic [SH_CW-1:0]     sh_cnt_inc;
    logic [INV_CW-1:0]    sh_invalid_inc;

    assign hdr_bad        = !sh_is_valid(HEADER_IN);
    assign sh_cnt_inc     = sh_cnt_q + SH_CW'(1);
    assign sh_invalid_inc = sh_invalid_cnt_q + INV_CW'(hdr_bad);

    // Next-state, counter and lock decisions for the sync FSM
    always_comb begin
        state_d          = state_q;
        sh_cnt_d         = sh_cnt_q;
        sh_invalid_cnt_d = sh_invalid_cnt_q;
        wait_cnt_d       = wait_cnt_q;
        block_lock_d     = block_lock_q;
        slip_d           = 1'b0;

        case (state_q)
            ST_TEST_SH: begin
                // Words without a strobe leave the whole machine untouched
                if (DATA_IN_VALID) begin
                    if (!block_lock_q) begin
                        if (hdr_bad) begin
                            // Any bad header while hunting means wrong alignment
                            state_d          = ST_SLIP;
                            slip_d           = 1'b1;
                            sh_cnt_d         = '0;
                            sh_invalid_cnt_d = '0;
                        end else if (sh_cnt_inc == SH_CNT_LAST) begin
                            block_lock_d     = 1'b1;
                            sh_cnt_d         = '0;
                            sh_invalid_cnt_d = '0;
                        end else begin
                            sh_cnt_d         = sh_cnt_inc;
                        end
                    end else begin
                        // Threshold check first: losing lock beats window end
                        if (sh_invalid_inc == INV_CNT_LAST) begin
                            block_lock_d     = 1'b0;
                            state_d          = ST_SLIP;
                            slip_d           = 1'b1;
                            sh_cnt_d         = '0;
                            sh_invalid_cnt_d = '0;
                        end else if (sh_cnt_inc == SH_CNT_LAST) begin
                            sh_cnt_d         = '0;
                            sh_invalid_cnt_d = '0;
                        end else begin
                            sh_cnt_d         = sh_cnt_inc;
                            sh_invalid_cnt_d = sh_invalid_inc;
                        end
                    end
                end
            end
            ST_SLIP: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                // Gearbox output is unreliable right after a slip; headers ignored
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = ST_TEST_SH;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CW'(1);
                end
            end
            default: begin
                state_d          = ST_TEST_SH;
                sh_cnt_d         = '0;
                sh_invalid_cnt_d = '0;
                wait_cnt_d       = '0;
                block_lock_d     = 1'b0;
            end
        endcase
    end

    // FSM state, counters, lock flag and slip pulse registers
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            state_q          <= ST_TEST_SH;
            sh_cnt_q         <= '0;
            sh_invalid_cnt_q <= '0;
            wait_cnt_q       <= '0;
            block_lock_q     <= 1'b0;
            slip_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            sh_cnt_q         <= sh_cnt_d;
            sh_invalid_cnt_q <= sh_invalid_cnt_d;
            wait_cnt_q       <= wait_cnt_d;
            block_lock_q     <= block_lock_d;
            slip_q           <= slip_d;
        end
    end

    // One-cycle registered pass-through of strobed words to the descrambler
    always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
        if (!SYSTEM_RESET_N) begin
            data_out_q       <= '0;
            header_out_q     <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            if (DATA_IN_VALID) begin
                data_out_q   <= DATA_IN;
                header_out_q <= HEADER_IN;
            end
            data_out_valid_q <= DATA_IN_VALID & block_lock_q;
        end
    end

    assign RXGEARBOX_SLIP = slip_q;
    assign BLOCK_LOCK     = block_lock_q;
    assign DATA_OUT       = data_out_q;
    assign HEADER_OUT     = header_out_q;
    assign DATA_OUT_VALID = data_out_valid_q;

endmodule

// File: tb/tb_block_sync.sv
// Directed-plus-random bench for block_sync. A behavioural model tracks the
// link as "words seen / bad headers in this window / cycles still ignored
// after a slip" and predicts every output each cycle.
module tb_block_sync;

    localparam int W    = 64;
    localparam int SHM  = 64;
    localparam int INVM = 16;
    localparam int SW   = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  din;
    logic [1:0]    hin;
    logic          vin;
    logic          slip_o;
    logic [W-1:0]  dout_o;
    logic [1:0]    hout_o;
    logic          dvalid_o;
    logic          lock_o;

    always #5 clk = ~clk;

    block_sync #(
        .RX_DATA_WIDTH      (W),
        .SH_CNT_MAX         (SHM),
        .SH_INVALID_CNT_MAX (INVM),
        .SLIP_WAIT          (SW)
    ) dut (
        .USER_CLK       (clk),
        .SYSTEM_RESET_N (rst_n),
        .DATA_IN        (din),
        .HEADER_IN      (hin),
        .DATA_IN_VALID  (vin),
        .RXGEARBOX_SLIP (slip_o),
        .DATA_OUT       (dout_o),
        .HEADER_OUT     (hout_o),
        .DATA_OUT_VALID (dvalid_o),
        .BLOCK_LOCK     (lock_o)
    );

    // Reference model state
    bit           m_lock;
    bit           m_slip;
    bit           m_dvalid;
    int           m_seen;
    int           m_bad;
    int           m_ignore;
    logic [W-1:0] m_dout;
    logic [1:0]   m_hout;

    int n_vec  = 0;
    int n_miss = 0;
    bit mask [64];

    task automatic model_reset();
        m_lock = 0; m_slip = 0; m_dvalid = 0;
        m_seen = 0; m_bad = 0; m_ignore = 0;
        m_dout = '0; m_hout = '0;
    endtask

    task automatic model_slip_event();
        m_slip   = 1;
        m_ignore = SW + 1;  // the slip cycle plus the settling period
        m_seen   = 0;
        m_bad    = 0;
    endtask

    // Apply one rising edge worth of inputs to the model
    task automatic model_edge(input bit v, input logic [1:0] h, input logic [W-1:0] d);
        bit bad;
        bad      = !(h == 2'b01 || h == 2'b10);
        m_dvalid = v && m_lock;
        if (v) begin
            m_dout = d;
            m_hout = h;
        end
        m_slip = 0;
        if (m_ignore > 0) begin
            m_ignore--;
        end else if (v) begin
            m_seen++;
            if (bad) m_bad++;
            if (!m_lock && bad) begin
                model_slip_event();
            end else if (m_lock && m_bad >= INVM) begin
                m_lock = 0;
                model_slip_event();
            end else if (m_seen >= SHM) begin
                m_lock = 1;
                m_seen = 0;
                m_bad  = 0;
            end
        end
    endtask

    task automatic check(input string where, input string what,
                         input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s/%s: observed %0h expected %0h", where, what, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check(where, "slip",   W'(slip_o),   W'(m_slip));
        check(where, "lock",   W'(lock_o),   W'(m_lock));
        check(where, "dvalid", W'(dvalid_o), W'(m_dvalid));
        check(where, "dout",   dout_o,       m_dout);
        check(where, "hout",   W'(hout_o),   W'(m_hout));
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
    endfunction

    // Drive one cycle from a negedge, advance model at posedge, check at negedge
    task automatic step(input string where, input bit v, input logic [1:0] h);
        logic [W-1:0] d;
        d   = {$urandom, $urandom};
        vin = v;
        hin = h;
        din = d;
        @(posedge clk);
        model_edge(v, h, d);
        @(negedge clk);
        check_all(where);
    endtask

    // Reset pulse placed between edges so its effect must be immediate
    task automatic async_reset(input string where);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(where);
        @(posedge clk);
        @(negedge clk);
        check_all(where);
        rst_n = 1'b1;
    endtask

    task automatic make_mask(input int nbad, input bit last_bad);
        int cnt;
        int p;
        for (int i = 0; i < 64; i++) mask[i] = 0;
        cnt = 0;
        if (last_bad) begin
            mask[63] = 1;
            cnt      = 1;
        end
        while (cnt < nbad) begin
            p = $urandom_range(0, 62);
            if (!mask[p]) begin
                mask[p] = 1;
                cnt++;
            end
        end
    endtask

    task automatic settle_and_lock(input string where);
        for (int i = 0; i < SW + 1; i++) step(where, $urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)));
        for (int i = 0; i < SHM; i++) step(where, 1'b1, good_hdr());
    endtask

    initial begin
        int widx;
        bit v;
        rst_n = 1'b1;
        vin   = 1'b0;
        hin   = 2'b00;
        din   = '0;
        model_reset();

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        $display("scenario 0: reset, slip=%0b lock=%0b", slip_o, lock_o);

        // Scenario 1: plain acquisition
        for (int i = 0; i < SHM - 1; i++) step("s1", 1'b1, good_hdr());
        check("s1", "lock_before_64", W'(lock_o), W'(0));
        step("s1", 1'b1, good_hdr());
        check("s1", "lock_at_64", W'(lock_o), W'(1));
        check("s1", "dvalid_at_64", W'(dvalid_o), W'(0));
        step("s1", 1'b1, good_hdr());
        check("s1", "dvalid_after", W'(dvalid_o), W'(1));
        $display("scenario 1: acquisition, lock=%0b dvalid=%0b", lock_o, dvalid_o);

        // Scenario 2: bad header at word 10 while hunting
        async_reset("s2_rst");
        for (int i = 0; i < 9; i++) step("s2", 1'b1, good_hdr());
        step("s2", 1'b1, 2'b11);
        check("s2", "slip_pulse", W'(slip_o), W'(1));
        for (int i = 0; i < SW + 1; i++) step("s2_wait", $urandom_range(0, 1) != 0, 2'($urandom_range(0, 3)));
        for (int i = 0; i < SHM - 1; i++) step("s2", 1'b1, good_hdr());
        check("s2", "lock_before_64", W'(lock_o), W'(0));
        step("s2", 1'b1, good_hdr());
        check("s2", "relock", W'(lock_o), W'(1));
        $display("scenario 2: slip and relock, lock=%0b", lock_o);

        // Scenario 3a: 15 bad headers in a window keeps lock
        make_mask(INVM - 1, 1'b0);
        widx = 0;
        while (widx < SHM) begin
            v = $urandom_range(0, 3) != 0;
            if (v) begin
                step("s3a", 1'b1, mask[widx] ? bad_hdr() : good_hdr());
                widx++;
            end else begin
                step("s3a", 1'b0, 2'($urandom_range(0, 3)));
            end
        end
        check("s3a", "lock_held", W'(lock_o), W'(1));
        // Scenario 3b: 16 bad headers drops lock
        make_mask(INVM, 1'b0);
        widx = 0;
        while (widx < SHM && !m_slip) begin
            step("s3b", 1'b1, mask[widx] ? bad_hdr() : good_hdr());
            widx++;
        end
        check("s3b", "lock_lost", W'(lock_o), W'(0));
        check("s3b", "slip", W'(slip_o), W'(1));
        $display("scenario 3: window threshold, lost at word %0d", widx);

        // Scenario 4: 16th bad header lands on the window's last word
        settle_and_lock("s4_lock");
        make_mask(INVM, 1'b1);
        for (int i = 0; i < SHM - 1; i++) step("s4", 1'b1, mask[i] ? bad_hdr() : good_hdr());
        check("s4", "lock_before_last", W'(lock_o), W'(1));
        step("s4", 1'b1, bad_hdr());
        check("s4", "lock_lost", W'(lock_o), W'(0));
        check("s4", "slip", W'(slip_o), W'(1));
        $display("scenario 4: coincident end and threshold, lock=%0b slip=%0b", lock_o, slip_o);

        // Scenario 5: strobe toggling during acquisition
        async_reset("s5_rst");
        for (int i = 0; i < 2 * SHM - 1; i++) begin
            if (i == 2 * SHM - 2) check("s5", "lock_before_64", W'(lock_o), W'(0));
            if (i % 2 == 0) step("s5", 1'b1, good_hdr());
            else step("s5", 1'b0, bad_hdr());
        end
        check("s5", "lock_at_64", W'(lock_o), W'(1));
        step("s5", 1'b0, bad_hdr());
        $display("scenario 5: gapped acquisition, lock=%0b", lock_o);

        // Scenario 6: reset while locked, then during WAIT
        async_reset("s6_rst_locked");
        for (int i = 0; i < 10; i++) step("s6", 1'b1, good_hdr());
        step("s6", 1'b1, bad_hdr());
        for (int i = 0; i < 5; i++) step("s6_wait", 1'b1, 2'($urandom_range(0, 3)));
        async_reset("s6_rst_wait");
        for (int i = 0; i < SHM - 1; i++) step("s6", 1'b1, good_hdr());
        check("s6", "lock_before_64", W'(lock_o), W'(0));
        step("s6", 1'b1, good_hdr());
        check("s6", "lock_at_64", W'(lock_o), W'(1));
        $display("scenario 6: reset mid-wait, lock=%0b", lock_o);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
